// File: rtl/sort_engine_if.sv
// Handshake and data bundle between the sort engine and its controller.
// The engine takes the slave side. The controller, or a bench, takes the master side.
interface sort_engine_if #(
    parameter int N = 8,
    parameter int W = 4
);
    localparam int CW = $clog2(N * (N - 1) / 2 + 1);
    localparam int PW = $clog2(N);

    logic             start;
    logic             desc;
    logic [N*W-1:0]   data_in;
    logic [N*W-1:0]   data_out;
    logic             busy;
    logic             done;
    logic [CW-1:0]    swap_cnt;
    logic [PW-1:0]    pass_cnt;

    modport master (
        output start, desc, data_in,
        input  data_out, busy, done, swap_cnt, pass_cnt
    );

    modport slave (
        input  start, desc, data_in,
        output data_out, busy, done, swap_cnt, pass_cnt
    );
endinterface

// File: rtl/sort_engine.sv
// Sequential bubble sort of N unsigned W-bit elements, ascending or descending.
// It does one compare/swap per clock and stops early after a pass with no swaps.
// The working registers drive data_out directly, so a display can show the swaps as they happen.
module sort_engine #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    sort_engine_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N * (N - 1) / 2 + 1);
    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMP,
        S_PEND,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_nextState;

    logic [W-1:0]    r_elem [N];
    logic            r_desc;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   r_limit;
    logic            r_swapped;
    logic [CW-1:0]   r_swapCnt;
    logic [PW-1:0]   r_passCnt;
    logic            r_busy;
    logic            r_done;

    logic [IW-1:0]   w_idxNext;
    logic [W-1:0]    w_left;
    logic [W-1:0]    w_right;
    logic            w_outOfOrder;
    logic            w_accept;
    logic            w_lastCmp;
    logic            w_finish;

    assign w_idxNext    = r_idx + IW'(1);
    assign w_left       = r_elem[r_idx];
    assign w_right      = r_elem[w_idxNext];
    // Equal values never count as out of order, which keeps the sort stable.
    assign w_outOfOrder = r_desc ? (w_left < w_right) : (w_left > w_right);
    assign w_lastCmp    = (r_idx == r_limit - IW'(1));
    assign w_finish     = !r_swapped || (r_limit == IW'(1));

    // State register, cleared asynchronously so a reset aborts a run at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode: start is honoured only when no run is in progress
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_nextState = S_CMP;
                end
            end
            S_CMP: begin
                if (w_lastCmp) begin
                    w_nextState = S_PEND;
                end
            end
            S_PEND: begin
                w_nextState = w_finish ? S_DONE : S_CMP;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Datapath: load on start, compare/swap in CMP, and close or reopen a pass in PEND
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                r_elem[i] <= '0;
            end
            r_desc    <= 1'b0;
            r_idx     <= '0;
            r_limit   <= '0;
            r_swapped <= 1'b0;
            r_swapCnt <= '0;
            r_passCnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (w_accept) begin
            for (int i = 0; i < N; i++) begin
                r_elem[i] <= bus.data_in[i*W +: W];
            end
            r_desc    <= bus.desc;
            r_idx     <= '0;
            r_limit   <= IW'(N - 1);
            r_swapped <= 1'b0;
            r_swapCnt <= '0;
            r_passCnt <= PW'(1);
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
        end else if (r_state == S_CMP) begin
            if (w_outOfOrder) begin
                r_elem[r_idx]     <= w_right;
                r_elem[w_idxNext] <= w_left;
                r_swapCnt         <= r_swapCnt + CW'(1);
                r_swapped         <= 1'b1;
            end
            if (!w_lastCmp) begin
                r_idx <= w_idxNext;
            end
        end else if (r_state == S_PEND) begin
            if (w_finish) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end else begin
                r_limit   <= r_limit - IW'(1);
                r_idx     <= '0;
                r_swapped <= 1'b0;
                r_passCnt <= r_passCnt + PW'(1);
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_out
            assign bus.data_out[g*W +: W] = r_elem[g];
        end
    endgenerate

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.swap_cnt = r_swapCnt;
    assign bus.pass_cnt = r_passCnt;
endmodule

// File: tb/tb_sort_engine.sv
// Self-checking bench for sort_engine.
// It drives an 8x4-bit instance and a 4x8-bit instance.
// Results are compared against a rank/inversion reference model.
module tb_sort_engine;
    logic clk;
    logic rst;

    int checks;
    int errors;

    int          tag8 [8];
    logic [31:0] prev8;

    sort_engine_if #(.N(8), .W(4)) bus8 ();
    sort_engine_if #(.N(4), .W(8)) bus4 ();

    sort_engine #(.N(8), .W(4)) u8 (.clk(clk), .rst(rst), .bus(bus8));
    sort_engine #(.N(4), .W(8)) u4 (.clk(clk), .rst(rst), .bus(bus4));

    // Free-running clock with rising edges at 5, 15, 25 and so on
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the final position is the element's stable rank.
    // The swap count is the number of inversions.
    // The pass count comes from the largest number of out-of-order predecessors of any element.
    function automatic void refModel(input int n, input int w, input logic [31:0] d, input logic ds,
                                     output logic [31:0] outv, output int swaps, output int passes,
                                     output int lat, output int pos [8]);
        int v [8];
        int m;
        int c;
        for (int i = 0; i < 8; i++) begin
            v[i]   = 0;
            pos[i] = 0;
        end
        for (int i = 0; i < n; i++) begin
            v[i] = int'((d >> (i * w)) & ((32'd1 << w) - 32'd1));
        end
        swaps = 0;
        m     = 0;
        for (int j = 0; j < n; j++) begin
            c = 0;
            for (int i = 0; i < j; i++) begin
                if (ds ? (v[i] < v[j]) : (v[i] > v[j])) c++;
            end
            swaps += c;
            if (c > m) m = c;
        end
        passes = (m + 1 < n - 1) ? m + 1 : n - 1;
        lat = 0;
        for (int p = 1; p <= passes; p++) lat += n + 1 - p;
        outv = '0;
        for (int j = 0; j < n; j++) begin
            for (int i = 0; i < n; i++) begin
                if ((ds ? (v[i] > v[j]) : (v[i] < v[j])) || (v[i] == v[j] && i < j)) pos[j]++;
            end
            outv = outv | (32'(v[j]) << (pos[j] * w));
        end
    endfunction

    task automatic startRun8(input logic [31:0] d, input logic ds);
        @(negedge clk);
        bus8.data_in = d;
        bus8.desc    = ds;
        bus8.start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        prev8      = d;
        for (int k = 0; k < 8; k++) tag8[k] = k;
    endtask

    task automatic startRun4(input logic [31:0] d, input logic ds);
        @(negedge clk);
        bus4.data_in = d;
        bus4.desc    = ds;
        bus4.start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.start = 1'b0;
    endtask

    // Wait for done on the 8-element instance.
    // Along the way, track which original element sits in each slot.
    // Optionally pulse start at a chosen edge.
    task automatic waitDone8(input int budget, input int pulseAt, input logic [31:0] pulseData,
                             output int lat, output bit busyOk);
        int k;
        lat    = -1;
        busyOk = 1'b1;
        for (int e = 1; e <= budget; e++) begin
            @(posedge clk);
            @(negedge clk);
            k = 0;
            while (k < 8 && bus8.data_out[k*4 +: 4] == prev8[k*4 +: 4]) k++;
            if (k < 7) begin
                int t;
                t           = tag8[k];
                tag8[k]     = tag8[k + 1];
                tag8[k + 1] = t;
            end
            prev8 = bus8.data_out;
            if (e == pulseAt - 1) begin
                bus8.start   = 1'b1;
                bus8.data_in = pulseData;
            end
            if (e == pulseAt) bus8.start = 1'b0;
            if (bus8.done) begin
                lat = e;
                if (bus8.busy) busyOk = 1'b0;
                break;
            end else if (!bus8.busy) begin
                busyOk = 1'b0;
            end
        end
    endtask

    task automatic waitDone4(input int budget, output int lat, output bit busyOk);
        lat    = -1;
        busyOk = 1'b1;
        for (int e = 1; e <= budget; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus4.done) begin
                lat = e;
                if (bus4.busy) busyOk = 1'b0;
                break;
            end else if (!bus4.busy) begin
                busyOk = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus8(input string tag, input logic [31:0] d, input logic ds,
                                  input int pulseAt, input logic [31:0] pulseData);
        logic [31:0] expOut;
        int expSw;
        int expPs;
        int expLat;
        int pos [8];
        int lat;
        bit busyOk;
        startRun8(d, ds);
        waitDone8(60, pulseAt, pulseData, lat, busyOk);
        refModel(8, 4, d, ds, expOut, expSw, expPs, expLat, pos);
        check({tag, ".latency"}, 64'(lat), 64'(expLat));
        check({tag, ".data"}, 64'(bus8.data_out), 64'(expOut));
        check({tag, ".swaps"}, 64'(bus8.swap_cnt), 64'(expSw));
        check({tag, ".passes"}, 64'(bus8.pass_cnt), 64'(expPs));
        check({tag, ".busy"}, 64'(busyOk), 64'(1));
        for (int j = 0; j < 8; j++) begin
            check({tag, ".stable"}, 64'(tag8[pos[j]]), 64'(j));
        end
    endtask

    task automatic applyStimulus4(input string tag, input logic [31:0] d, input logic ds);
        logic [31:0] expOut;
        int expSw;
        int expPs;
        int expLat;
        int pos [8];
        int lat;
        bit busyOk;
        startRun4(d, ds);
        waitDone4(20, lat, busyOk);
        refModel(4, 8, d, ds, expOut, expSw, expPs, expLat, pos);
        check({tag, ".latency"}, 64'(lat), 64'(expLat));
        check({tag, ".data"}, 64'(bus4.data_out), 64'(expOut));
        check({tag, ".swaps"}, 64'(bus4.swap_cnt), 64'(expSw));
        check({tag, ".passes"}, 64'(bus4.pass_cnt), 64'(expPs));
        check({tag, ".busy"}, 64'(busyOk), 64'(1));
    endtask

    // Directed scenarios first, then randomized runs on both instances
    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b0;
        bus8.start   = 1'b0;
        bus8.desc    = 1'b0;
        bus8.data_in = '0;
        bus4.start   = 1'b0;
        bus4.desc    = 1'b0;
        bus4.data_in = '0;

        #12;
        check("reset.data", 64'(bus8.data_out), 64'(0));
        check("reset.busy", 64'(bus8.busy), 64'(0));
        check("reset.done", 64'(bus8.done), 64'(0));
        check("reset.swaps", 64'(bus8.swap_cnt), 64'(0));
        check("reset.passes", 64'(bus8.pass_cnt), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        applyStimulus8("sorted", 32'h76543210, 1'b0, 0, '0);
        check("sorted.lat8", 64'(bus8.done), 64'(1));
        applyStimulus8("reversed", 32'h01234567, 1'b0, 0, '0);
        check("reversed.const", 64'(bus8.data_out), 64'h76543210);
        applyStimulus8("desc", 32'h62951413, 1'b1, 0, '0);
        check("desc.const", 64'(bus8.data_out), 64'h11234569);

        applyStimulus8("ignored", 32'h01234567, 1'b0, 5, 32'h55555555);
        check("ignored.const", 64'(bus8.data_out), 64'h76543210);
        startRun8(32'h22222222, 1'b0);
        check("restart.doneLow", 64'(bus8.done), 64'(0));
        check("restart.busyHigh", 64'(bus8.busy), 64'(1));
        begin
            int lat;
            bit busyOk;
            waitDone8(60, 0, '0, lat, busyOk);
            check("restart.latency", 64'(lat), 64'(8));
            check("restart.swaps", 64'(bus8.swap_cnt), 64'(0));
            check("restart.data", 64'(bus8.data_out), 64'h22222222);
        end

        startRun8(32'h01234567, 1'b0);
        for (int e = 1; e <= 10; e++) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort.data", 64'(bus8.data_out), 64'(0));
        check("abort.busy", 64'(bus8.busy), 64'(0));
        check("abort.done", 64'(bus8.done), 64'(0));
        check("abort.swaps", 64'(bus8.swap_cnt), 64'(0));
        check("abort.passes", 64'(bus8.pass_cnt), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        applyStimulus8("afterAbort", 32'h62951413, 1'b0, 0, '0);

        applyStimulus4("wide", 32'h7F8000FF, 1'b0);
        check("wide.const", 64'(bus4.data_out), 64'hFF807F00);

        for (int r = 0; r < 1000; r++) begin
            applyStimulus4("rand4", $urandom, 1'($urandom_range(0, 1)));
        end
        for (int r = 0; r < 200; r++) begin
            applyStimulus8("rand8", $urandom, 1'($urandom_range(0, 1)), 0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sort_engine.md
Name: sort_engine

Overview:
- Parametrised sequential bubble-sort engine: the successor to the fixed four-nibble sorter.
- Sorts N unsigned W-bit elements, ascending or descending, selectable per run.
- Performs one compare/swap per clock and ends early when a pass makes no swaps.
- Working registers are exposed live, so the board display or LEDs can show progress; start/done handshake and swap/pass statistics go to the top-level control logic.

Parameters:
- N, 8, number of elements; must be ≥2.
- W, 4, element width in bits; comparison is unsigned.
- Derived: IW = $clog2(N) (index width); CW = $clog2(N*(N-1)/2+1) (swap-counter width); PW = $clog2(N) (pass-counter width, must hold N-1).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  request a sort run; sampled only in IDLE or DONE.
- desc  in  1  order select: 0 = ascending, 1 = descending; latched on accepted start.
- data_in  in  N*W  element i at bits [i*W +: W]; captured on accepted start.
- data_out  out  N*W  working registers, element i at [i*W +: W]; valid as the final result while done=1.
- busy  out  1  high while sorting.
- done  out  1  high from completion until the next accepted start or reset.
- swap_cnt  out  CW  number of swaps performed in the current or last run.
- pass_cnt  out  PW  number of passes started in the current or last run.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all working registers 0; data_out=0; busy=0; done=0; swap_cnt=0; pass_cnt=0. Reset at any point, including mid-sort, aborts immediately. No partial result is retained.
- States:
  - IDLE: waiting for start.
  - CMP: one compare per cycle.
  - PEND: end-of-pass decision.
  - DONE: result held.
- Accepted start (start=1 in IDLE or DONE), on the same edge:
  - load regs from data_in and latch desc;
  - idx=0, limit=N-1, swapped=0;
  - swap_cnt=0, pass_cnt=1;
  - done=0, busy=1; go to CMP.
- start while in CMP or PEND is ignored; the run in progress is unaffected.
- CMP, each edge:
  - Compare r[idx] with r[idx+1]. Out of order means r[idx]>r[idx+1] when ascending, r[idx]<r[idx+1] when descending.
  - If out of order: swap the pair, increment swap_cnt, set swapped=1.
  - Equal elements are never swapped (stable).
  - If idx==limit-1, go to PEND; otherwise idx=idx+1.
- PEND, one edge:
  - If swapped==0 or limit==1: go to DONE, busy=0, done=1.
  - Otherwise: limit=limit-1, idx=0, swapped=0, pass_cnt=pass_cnt+1, return to CMP.
- DONE: registers, counters and done are held; done stays high until an accepted start or reset.
- Latency, counted in edges after the start edge until done reads 1:
  - sum over executed passes of (compares in the pass + 1);
  - already sorted input: N edges;
  - fully reversed input: N(N+1)/2 - 1 edges (35 for N=8).
- data_out is continuous from the working registers, so intermediate swaps are visible.
- Counters never wrap: the maximum swap count is N(N-1)/2, and CW is sized to hold it.
- Control logic is synchronous to clk only. No combinational path from inputs to outputs.

Test Plan:
- Default N=8, W=4, ascending, data_in {0,1,2,3,4,5,6,7} (element 0 first) -> done rises 8 edges after start; data_out unchanged; swap_cnt=0; pass_cnt=1.
- Ascending, {7,6,5,4,3,2,1,0} -> done after exactly 35 edges; data_out {0..7}; swap_cnt=28; pass_cnt=7; busy high throughout, low with done.
- desc=1, {3,1,4,1,5,9,2,6} -> data_out {9,6,5,4,3,2,1,1}; both 1s end in their original relative order (tag them via a scoreboard swap trace); swap_cnt matches the reference-model count.
- Handshake: during a reversed-input run, pulse start with different data_in at edge 5 -> ignored, original result produced. Then start from DONE with {2,2,2,2,2,2,2,2} -> done drops on the start edge and returns after 8 edges; swap_cnt=0.
- Drive rst=0 asynchronously mid-run (between edges, at edge 10 of a reversed run) -> data_out, busy, done and counters go to 0 immediately. After rst=1, a new start sorts correctly.
- Instance N=4, W=8, ascending, {0xFF,0x00,0x80,0x7F} -> data_out {0x00,0x7F,0x80,0xFF} (unsigned compare); done within 9 edges; also randomised 1000 runs against a software sort model.
